kbd_responder: RTL and testbench
================================

Name: kbd_responder

Overview:
- Memory-mapped keyboard peripheral answering the kbd region of the address decoder (sel_kbd / dout_kbd).
- Receives PS/2 device-to-host frames, buffers scan codes in a FIFO, and serves CPU reads of data and status registers.
- A data read pops one entry.
- Sits between the PS/2 pins and the SoC bus. The decoder muxes dout combinationally, so read data is combinational.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- TIMEOUT, 50000: clk cycles without a falling ps2_clk edge mid-frame before the receiver aborts.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous.
- ps2_data  input  1  raw PS/2 data, asynchronous.
- sel  input  1  region select from the address decoder.
- rd_en  input  1  CPU load strobe, qualified by sel.
- wr_en  input  1  CPU store strobe, qualified by sel.
- addr  input  4  byte offset within the region; addr[1:0] ignored.
- din  input  32  store data.
- dout  output  32  read data, combinational from addr and state.
- irq  output  1  high while FIFO is non-empty.

Behaviour:
- Reset (rst high at a clk edge): FIFO empty, count=0, overflow=0, parity_err=0, receiver IDLE, synchronizers cleared to 1. Resulting outputs: irq=0; dout for offset 0x0 reads 0.
- Synchronization: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A falling edge is synced ps2_clk previous=1, current=0. Data is sampled on the edge cycle.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on an edge with data=0 (start bit), go to DATA with bit index 0. An edge with data=1 is ignored.
  - DATA: on each edge, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on an edge, latch the parity bit and go to STOP.
  - STOP: on an edge, if data=1 and the parity check passes, push the byte; otherwise set the sticky parity_err and drop the byte. Return to IDLE either way.
  - A timeout counter resets on every edge. In any state other than IDLE, reaching TIMEOUT returns to IDLE and discards the partial byte; flags are unchanged.
- Parity: odd over the 8 data bits plus the parity bit.
- FIFO: circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH, plus a count from 0 to DEPTH.
  - Push when full: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle on a non-empty FIFO: both take effect and count is unchanged.
  - Pop on empty: no effect.
  - Push and pop in the same cycle on an empty FIFO: push only.
- Register map (word offsets):
  - 0x0 DATA, read-only: {23'b0, valid, head byte}, where valid = (count != 0); reads 0 when empty. A cycle with sel & rd_en & offset 0x0 & non-empty pops at that clk edge. Data is visible in the same cycle, before the pop.
  - 0x4 STATUS: read {16'b0, count in [15:8], 6'b0, parity_err, overflow}. Writing din[0]=1 clears overflow; din[1]=1 clears parity_err. If a clear and a set land on the same edge, the set wins.
  - 0x8 CTRL, write-only: din[0]=1 flushes the FIFO (pointers and count to 0). A push in the same cycle is discarded. Reads 0.
  - 0xC and any unmapped offset: read 0, writes ignored.
- sel=0: no pop, no register write; dout still driven (decoder discards it).
- rd_en and wr_en both high: both act.
- rst mid-frame: abandons the frame; no push.

Optional Feature:
- Macro KBD_PARITY_CHECK_EN.
- Defined: a parity failure drops the byte and sets parity_err.
- Undefined: the parity bit is ignored. Any frame with stop=1 is pushed; parity_err stays 0 and is read as 0; a bad stop bit is still dropped silently.

Decomposition:
- Package kbd_pkg holds:
  - register offset constants KBD_DATA=4'h0, KBD_STATUS=4'h4, KBD_CTRL=4'h8;
  - the receiver state enum (IDLE, DATA, PARITY, STOP);
  - STATUS bit-position constants.
- One sub-module ps2_rx: synchronizers, FSM and timeout. Outputs a byte_valid pulse, byte and frame_err. The FIFO and register logic stay in kbd_responder.

Test Plan:
- Reset, then a frame for 0x1C with parity 0 and stop 1 -> one cycle after the stop edge: irq=1; read 0x0 returns 0x0000011C; next cycle count=0 and irq=0.
- Nine frames 0x01..0x09 with DEPTH=8 -> STATUS=0x00000801; eight DATA reads return 0x101..0x108 in order; a ninth read returns 0.
- Frame 0x1C with parity bit 1 (KBD_PARITY_CHECK_EN defined) -> no push; STATUS=0x00000002; write STATUS din=0x2 -> STATUS reads 0.
- Start bit plus 3 data bits, then idle for TIMEOUT+1 cycles, then a clean 0xF0 frame -> only 0xF0 in the FIFO; no flags set.
- FIFO holding 2 entries, a DATA read coinciding with a push edge -> count stays 2; order preserved.
- CTRL write 0x1 with 4 entries -> count=0, irq=0; rst asserted mid-frame -> FIFO empty and the next full frame is received correctly.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: register offsets, STATUS bit positions and receiver state type for the keyboard peripheral
package kbd_pkg;
  localparam logic [3:0] KBD_DATA = 4'h0;
  localparam logic [3:0] KBD_STATUS = 4'h4;
  localparam logic [3:0] KBD_CTRL = 4'h8;
  localparam int ST_OVF = 0;
  localparam int ST_PERR = 1;
  localparam int ST_CNT = 8;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronizes the PS/2 pins and deframes device-to-host bytes with a mid-frame timeout
// Odd-parity enforcement is enabled by defining KBD_PARITY_CHECK_EN.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
`ifdef KBD_PARITY_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif
  localparam int TW = $clog2(TIMEOUT + 1);
  rx_state_t state, state_n;
  logic [1:0] clk_s, dat_s;
  logic clk_prev, fall, dat, par, ok, stop_edge;
  logic [2:0] idx;
  logic [7:0] sh;
  logic [TW-1:0] cnt;
  assign dat = dat_s[1];
  assign fall = clk_prev & ~clk_s[1];
  assign stop_edge = fall & (state == STOP);
  assign ok = dat & (~PCHK | ^{sh, par});
  assign byte_valid = stop_edge & ok;
  assign frame_err = stop_edge & ~ok & PCHK;
  assign rx_byte = sh;
  always_comb begin
    state_n = state;
    if (fall)
      case (state)
        IDLE:    state_n = dat ? IDLE : DATA;
        DATA:    state_n = (idx == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: state_n = IDLE;
      endcase
    else if (state != IDLE && cnt == TW'(TIMEOUT - 1))
      state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_prev <= 1'b1;
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      cnt <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      clk_prev <= clk_s[1];
      state <= state_n;
      cnt <= (fall || state == IDLE) ? '0 : cnt + 1'b1;
      if (fall && state == IDLE) idx <= '0;
      if (fall && state == DATA) begin
        sh <= {dat, sh[7:1]};
        idx <= idx + 1'b1;
      end
      if (fall && state == PARITY) par <= dat;
    end
endmodule

// File: rtl/kbd_responder.sv
// kbd_responder: memory-mapped PS/2 keyboard with scan-code FIFO, DATA/STATUS/CTRL registers and irq
// Parity enforcement in the receiver is enabled by defining KBD_PARITY_CHECK_EN.
module kbd_responder
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        sel,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [7:0] rx_byte;
  logic [3:0] off;
  logic [31:0] status;
  logic overflow, parity_err, byte_valid, frame_err;
  logic nonempty, full, pop, push, flush, stat_wr, unused_bits;
  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .byte_valid(byte_valid),
    .rx_byte(rx_byte),
    .frame_err(frame_err)
  );
  assign unused_bits = ^{din[31:2], addr[1:0]};
  assign off = {addr[3:2], 2'b00};
  assign nonempty = count != '0;
  assign full = count == CAP;
  assign pop = sel & rd_en & (off == KBD_DATA) & nonempty;
  assign flush = sel & wr_en & (off == KBD_CTRL) & din[0];
  assign stat_wr = sel & wr_en & (off == KBD_STATUS);
  assign push = byte_valid & ~flush & ~full;
  assign irq = nonempty;
  always_comb begin
    status = '0;
    status[ST_OVF] = overflow;
    status[ST_PERR] = parity_err;
    status[ST_CNT +: 8] = 8'(count);
    dout = (off == KBD_DATA && nonempty) ? {23'b0, 1'b1, mem[rp]} :
           (off == KBD_STATUS) ? status : '0;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= rx_byte;
  // Sets are ORed after the clear mask so a same-edge set wins over a software clear.
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      wp <= flush ? '0 : wp + AW'(push);
      rp <= flush ? '0 : rp + AW'(pop);
      count <= flush ? '0 : count + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow <= (byte_valid & full & ~flush) | (overflow & ~(stat_wr & din[0]));
      parity_err <= frame_err | (parity_err & ~(stat_wr & din[1]));
    end
endmodule

// File: tb/tb_kbd_responder.sv
// tb_kbd_responder: table-driven, directed and randomized checks of kbd_responder against a queue model
module tb_kbd_responder;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 100;
  localparam int HP = 5;
`ifdef KBD_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic sel = 1'b0, rd_en = 1'b0, wr_en = 1'b0, irq;
  logic [3:0] addr = '0;
  logic [31:0] din = '0, dout;
  int vectors = 0, miscompares = 0;
  byte unsigned q[$];
  bit m_ovf, m_perr;
  event stop_fall;
  typedef struct {
    logic [7:0] d;
    bit pbad;
    bit stop;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[6];

  kbd_responder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .sel(sel),
    .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit pbad, input bit stop, input int nbits = 11);
    logic [10:0] f;
    f = {stop, (~(^d)) ^ pbad, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) -> stop_fall;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic void model_frame(input logic [7:0] d, input bit pbad, input bit stop);
    if (stop && !(PCHK && pbad)) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(d);
    end else if (PCHK) m_perr = 1'b1;
  endfunction

  task automatic frame(input logic [7:0] d, input bit pbad, input bit stop);
    send_frame(d, pbad, stop);
    model_frame(d, pbad, stop);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; rd_en = 1'b1; addr = a;
    #1 d = dout;
    @(negedge clk);
    sel = 1'b0; rd_en = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] v);
    sel = 1'b1; wr_en = 1'b1; addr = a; din = v;
    @(negedge clk);
    sel = 1'b0; wr_en = 1'b0; din = '0;
  endtask

  task automatic rd_model(input logic [3:0] a, input string nm);
    logic [31:0] e, g;
    if (a[3:2] == 2'd1) e = {16'b0, 8'(q.size()), 6'b0, m_perr, m_ovf};
    else if (a[3:2] == 2'd0 && q.size() != 0) e = {23'b0, 1'b1, q[0]};
    else e = 32'h0;
    bus_rd(a, g);
    if (a[3:2] == 2'd0 && q.size() != 0) void'(q.pop_front());
    chk(nm, g, e);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_perr = 1'b0;
  endtask

  initial begin
    logic [31:0] g;
    tbl[0] = '{8'h1C, 1'b0, 1'b1, 32'h100, 32'h11C};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, PCHK ? 32'h2 : 32'h100, PCHK ? 32'h0 : 32'h11C};
    tbl[2] = '{8'hF0, 1'b0, 1'b0, PCHK ? 32'h2 : 32'h0, 32'h0};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 32'h100, 32'h100};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 32'h100, 32'h1FF};
    tbl[5] = '{8'hA5, 1'b1, 1'b0, PCHK ? 32'h2 : 32'h0, 32'h0};
    do_reset();
    chk("reset_irq", irq, 0);
    bus_rd(4'h0, g); chk("reset_data", g, 0);
    bus_rd(4'h4, g); chk("reset_status", g, 0);
    bus_rd(4'h8, g); chk("reset_ctrl", g, 0);
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].pbad, tbl[i].stop);
      bus_rd(4'h4, g); chk($sformatf("tbl%0d_status", i), g, tbl[i].exp_status);
      bus_rd(4'h0, g); chk($sformatf("tbl%0d_data", i), g, tbl[i].exp_data);
      bus_wr(4'h4, 32'h3);
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("single_irq", irq, 1);
    rd_en = 1'b1; addr = 4'h0;
    @(negedge clk);
    rd_en = 1'b0;
    bus_rd(4'h4, g); chk("unselected_no_pop", g, 32'h100);
    bus_rd(4'h0, g); chk("single_data", g, 32'h11C);
    chk("single_irq_after_pop", irq, 0);
    bus_rd(4'h4, g); chk("single_count_after_pop", g, 0);
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    bus_rd(4'h4, g); chk("full_status", g, 32'h801);
    for (int i = 1; i <= 8; i++) begin
      bus_rd(4'h0, g); chk($sformatf("full_read%0d", i), g, 32'h100 + i);
    end
    bus_rd(4'h0, g); chk("empty_read", g, 0);
    bus_wr(4'h4, 32'h1);
    bus_rd(4'h4, g); chk("ovf_cleared", g, 0);
    send_frame(8'h1C, 1'b1, 1'b1);
    bus_rd(4'h4, g); chk("perr_status", g, PCHK ? 32'h2 : 32'h100);
    bus_wr(4'h4, 32'h2);
    bus_rd(4'h4, g); chk("perr_cleared", g, PCHK ? 32'h0 : 32'h100);
    bus_rd(4'h0, g); chk("perr_data", g, PCHK ? 32'h0 : 32'h11C);
    send_frame(8'h00, 1'b0, 1'b1, 4);
    repeat (TIMEOUT + 1) @(negedge clk);
    send_frame(8'hF0, 1'b0, 1'b1);
    bus_rd(4'h4, g); chk("timeout_status", g, 32'h100);
    bus_rd(4'h0, g); chk("timeout_data", g, 32'h1F0);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    fork
      send_frame(8'h33, 1'b0, 1'b1);
      begin
        @(stop_fall);
        repeat (2) @(negedge clk);
        bus_rd(4'h0, g);
      end
    join
    chk("coincide_data", g, 32'h111);
    bus_rd(4'h4, g); chk("coincide_status", g, 32'h200);
    bus_rd(4'h0, g); chk("coincide_next1", g, 32'h122);
    bus_rd(4'h0, g); chk("coincide_next2", g, 32'h133);
    for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b1);
    bus_rd(4'h7, g); chk("alias_status", g, 32'h400);
    bus_rd(4'hC, g); chk("unmapped_read", g, 0);
    bus_wr(4'hC, 32'h1);
    bus_wr(4'h8, 32'h1);
    bus_rd(4'h4, g); chk("flush_status", g, 0);
    chk("flush_irq", irq, 0);
    send_frame(8'h77, 1'b0, 1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1);
    bus_rd(4'h0, g); chk("post_rst_data", g, 32'h15A);
    bus_rd(4'h4, g); chk("post_rst_status", g, 0);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
      chk("rand_irq", irq, q.size() != 0);
      case ($urandom_range(0, 5))
        0, 1: rd_model(4'h0, "rand_data");
        2: rd_model(4'h4, "rand_status");
        3: begin
          g = 32'($urandom_range(0, 3));
          bus_wr(4'h4, g);
          if (g[0]) m_ovf = 1'b0;
          if (g[1]) m_perr = 1'b0;
        end
        4: if ($urandom_range(0, 3) == 0) begin
          bus_wr(4'h8, 32'h1);
          q.delete();
        end else rd_model(4'hC, "rand_unmapped");
        default: ;
      endcase
    end
    rd_model(4'h4, "drain_status");
    for (int i = 0; i <= DEPTH; i++) rd_model(4'h0, "drain_data");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
